// File: rtl/mem_load_formatter.sv
// MEM-stage load path: word read over req/ack, pipeline stall while pending,
// byte/half/word extraction with sign/zero extension, registered result.
module mem_load_formatter #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load_valid,
   input  logic [5:0]        i_opcode,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_stall,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [31:0]       i_mem_rdata,
   output logic [31:0]       o_load_data,
   output logic              o_load_valid,
   output logic              o_load_err
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t        state;
   state_t        nxt;
   logic [5:0]    op_q;
   logic [CW-1:0] cnt;
   logic          err_q;
   logic          is_load;
   logic          start;
   logic          timeout;
   logic [31:0]   fmt;

   always_comb begin
      is_load = 1'b0;
      case (i_opcode)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
         default: is_load = 1'b0;
      endcase
   end

   assign start   = i_load_valid & is_load;
   assign timeout = (cnt == LAST);

   // Extraction uses the opcode latched at start, not the live MEM opcode.
   always_comb begin
      fmt = i_mem_rdata;
      case (op_q)
         OP_LB:   fmt = {{24{i_mem_rdata[7]}}, i_mem_rdata[7:0]};
         OP_LBU:  fmt = {24'b0, i_mem_rdata[7:0]};
         OP_LH:   fmt = {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
         OP_LHU:  fmt = {16'b0, i_mem_rdata[15:0]};
         default: fmt = i_mem_rdata;
      endcase
   end

   always_comb begin
      nxt          = state;
      o_stall      = 1'b0;
      o_mem_req    = 1'b0;
      o_load_valid = 1'b0;
      o_load_err   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               o_stall = 1'b1;
               nxt     = REQ;
            end
         end
         REQ: begin
            o_stall   = 1'b1;
            o_mem_req = 1'b1;
            if (i_mem_ack || timeout) nxt = DONE;
         end
         DONE: begin
            o_load_valid = 1'b1;
            o_load_err   = err_q;
            nxt          = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         op_q        <= '0;
         o_mem_addr  <= '0;
         cnt         <= '0;
         o_load_data <= '0;
         err_q       <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q       <= i_opcode;
                  o_mem_addr <= i_addr;
                  cnt        <= '0;
                  err_q      <= 1'b0;
               end
            end
            REQ: begin
               cnt <= cnt + CW'(1);
               // A late ack on the final cycle still beats the timeout.
               if (i_mem_ack) begin
                  o_load_data <= fmt;
                  err_q       <= 1'b0;
               end else if (timeout) begin
                  o_load_data <= '0;
                  err_q       <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_load_formatter.sv
// Bench for mem_load_formatter: directed cases plus randomized loads
// checked against a transaction-level reference model.
module tb_mem_load_formatter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        lv;
   logic [5:0]  op;
   logic [31:0] addr;
   logic        stall;
   logic        req;
   logic [31:0] maddr;
   logic        ack;
   logic [31:0] rdata;
   logic [31:0] ld;
   logic        lvalid;
   logic        lerr;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_data;

   logic [5:0] ops [5];

   mem_load_formatter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_load_valid(lv),
      .i_opcode    (op),
      .i_addr      (addr),
      .o_stall     (stall),
      .o_mem_req   (req),
      .o_mem_addr  (maddr),
      .i_mem_ack   (ack),
      .i_mem_rdata (rdata),
      .o_load_data (ld),
      .o_load_valid(lvalid),
      .o_load_err  (lerr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_fmt(input logic [5:0] o,
                                           input logic [31:0] d);
      logic [31:0] b;
      logic [31:0] h;
      b = d % 256;
      h = d % 65536;
      case (o)
         6'b100000: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         6'b100100: return b;
         6'b100001: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         6'b100101: return h;
         6'b100011: return d;
         default:   return 32'h0;
      endcase
   endfunction

   // delay = REQ cycles without ack before the ack cycle; >= TO means none.
   task automatic do_load(input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] d, input int delay);
      logic        exp_err;
      logic [31:0] exp_data;
      int          nreq;
      lv   = 1'b1;
      op   = o;
      addr = a;
      ack  = 1'b0;
      #1;
      chk("start_stall", 32'(stall), 1);
      chk("start_req", 32'(req), 0);
      tick;
      nreq = 0;
      for (int k = 0; k < TO; k++) begin
         lv   = 1'($urandom_range(0, 1));
         op   = ops[$urandom_range(0, 4)];
         addr = $urandom;
         chk("req_hi", 32'(req), 1);
         chk("req_stall", 32'(stall), 1);
         chk("req_addr", maddr, a);
         chk("req_novalid", 32'(lvalid), 0);
         nreq++;
         if (k == delay) begin
            ack   = 1'b1;
            rdata = d;
         end else begin
            ack   = 1'b0;
            rdata = $urandom;
         end
         tick;
         if (k == delay) break;
      end
      exp_err  = (delay >= TO);
      exp_data = exp_err ? 32'h0 : ref_fmt(o, d);
      chk("req_cycles", 32'(nreq), exp_err ? TO : delay + 1);
      ack = 1'b0;
      lv  = 1'b1;
      op  = 6'b100011;
      #1;
      chk("done_valid", 32'(lvalid), 1);
      chk("done_err", 32'(lerr), 32'(exp_err));
      chk("done_data", ld, exp_data);
      chk("done_stall", 32'(stall), 0);
      chk("done_req", 32'(req), 0);
      last_data = exp_data;
      tick;
      lv = 1'b0;
      #1;
      chk("post_valid", 32'(lvalid), 0);
      chk("post_req", 32'(req), 0);
      chk("post_hold", ld, last_data);
   endtask

   initial begin
      ops[0] = 6'b100000;
      ops[1] = 6'b100100;
      ops[2] = 6'b100001;
      ops[3] = 6'b100101;
      ops[4] = 6'b100011;
      rst   = 1'b1;
      lv    = 1'b0;
      op    = 6'b0;
      addr  = 32'h0;
      ack   = 1'b0;
      rdata = 32'h0;
      tick;
      tick;
      chk("rst_req", 32'(req), 0);
      chk("rst_addr", maddr, 0);
      chk("rst_data", ld, 0);
      chk("rst_valid", 32'(lvalid), 0);
      chk("rst_err", 32'(lerr), 0);
      chk("rst_stall", 32'(stall), 0);
      rst = 1'b0;
      tick;

      do_load(6'b100000, 32'h0000_1000, 32'h1234_5680, 0);
      chk("lb_value", ld, 32'hFFFF_FF80);
      do_load(6'b100100, 32'h0000_2004, 32'hCAFE_8001, 0);
      chk("lbu_value", ld, 32'h0000_0001);
      do_load(6'b100101, 32'h0000_2008, 32'hCAFE_8001, 1);
      chk("lhu_value", ld, 32'h0000_8001);
      do_load(6'b100001, 32'h0000_200C, 32'hCAFE_8001, 2);
      chk("lh_value", ld, 32'hFFFF_8001);
      do_load(6'b100011, 32'h0000_2010, 32'hCAFE_8001, 5);
      chk("lw_value", ld, 32'hCAFE_8001);
      do_load(6'b100011, 32'hDEAD_0000, 32'h1111_1111, TO);
      chk("timeout_data", ld, 32'h0);
      do_load(6'b100011, 32'hBEEF_0000, 32'h7777_1234, TO - 1);
      chk("late_ack", ld, 32'h7777_1234);

      lv   = 1'b1;
      op   = 6'b101011;
      addr = 32'h0000_3000;
      #1;
      chk("sw_stall", 32'(stall), 0);
      tick;
      lv    = 1'b0;
      ack   = 1'b1;
      rdata = 32'h5555_AAAA;
      chk("sw_req", 32'(req), 0);
      tick;
      ack = 1'b0;
      chk("stray_valid", 32'(lvalid), 0);
      chk("stray_req", 32'(req), 0);
      chk("stray_data", ld, last_data);

      lv   = 1'b1;
      op   = 6'b100011;
      addr = 32'h0000_4000;
      tick;
      lv = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rmid_req", 32'(req), 1);
         tick;
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("rmid_req_drop", 32'(req), 0);
      chk("rmid_stall", 32'(stall), 0);
      chk("rmid_novalid", 32'(lvalid), 0);
      tick;
      chk("rmid_novalid2", 32'(lvalid), 0);
      chk("rmid_data", ld, 0);
      do_load(6'b100001, 32'h0000_4010, 32'h0000_7FFE, 1);
      chk("rmid_lh", ld, 32'h0000_7FFE);

      for (int n = 0; n < 40; n++) begin
         int dly;
         dly = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 6);
         do_load(ops[$urandom_range(0, 4)], $urandom, $urandom, dly);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
